// File: rtl/traffic_pkg.sv
// traffic_pkg: command codes and helpers shared by the command issuer and the
// traffic light controller, so both ends of the command bus agree on encodings.
package traffic_pkg;

  typedef enum logic [2:0] {
    TURN_ON         = 3'd0,
    TURN_OFF        = 3'd1,
    SET_UNC         = 3'd2,
    SET_GREEN_TIME  = 3'd3,
    SET_RED_TIME    = 3'd4,
    SET_YELLOW_TIME = 3'd5
  } cmd_type_t;

  localparam logic [2:0] CMD_TYPE_MAX = 3'd5;

  // One buffered command: raw 3-bit code plus 16-bit time value.
  typedef struct packed {
    logic [2:0]  cmd_type;
    logic [15:0] data;
  } cmd_entry_t;

  // True for the codes whose data field carries a time value.
  function automatic logic is_set_time(cmd_type_t t);
    return (t == SET_GREEN_TIME) || (t == SET_RED_TIME) || (t == SET_YELLOW_TIME);
  endfunction

endpackage

// File: rtl/traffic_cmd_fifo.sv
// traffic_cmd_fifo: synchronous FIFO of {type, data} command entries.
// flush discards the contents; a push in the same cycle becomes the sole entry.
module traffic_cmd_fifo
  import traffic_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  cmd_entry_t                   wr_entry,
  output cmd_entry_t                   rd_entry,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  cmd_entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_idx;

  assign wr_idx   = flush ? '0 : wr_ptr;
  assign rd_entry = mem[rd_ptr];
  assign full     = (level == LW'(FIFO_DEPTH));
  assign empty    = (level == '0);

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PW'(1) : '0;
      level  <= push ? LW'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Entry storage; no reset needed since validity is tracked by level.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_idx] <= wr_entry;
  end

endmodule

// File: rtl/traffic_cmd_issuer.sv
// traffic_cmd_issuer: validates host requests, buffers them, and issues them to
// the controller as single-cycle cmd_valid_o pulses separated by CMD_GAP idle cycles.
// Optional: TRAFFIC_CMD_OFF_BYPASS_EN makes an accepted TURN_OFF flush the queue.
module traffic_cmd_issuer
  import traffic_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CMD_GAP    = 2,
  parameter int unsigned MIN_TIME   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [2:0]                   req_type_i,
  input  logic [15:0]                  req_data_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  output logic [2:0]                   cmd_type_o,
  output logic [15:0]                  cmd_data_o,
  output logic                         cmd_valid_o,
  output logic                         err_o,
  output logic                         busy_o,
  output logic [$clog2(FIFO_DEPTH):0]  level_o
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t      state;
  logic [7:0]  gap_cnt;

  logic        accept;
  logic        legal;
  logic        stage_nxt;
  logic        stage_vld;
  cmd_entry_t  stage_entry;
  cmd_entry_t  head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        flush;
  logic [LW-1:0] lvl_nxt;
  logic [LW:0]   occ_nxt;
  logic        ready_nxt;

  assign accept    = req_valid_i && req_ready_o;
  assign legal     = (req_type_i <= CMD_TYPE_MAX) &&
                     !(is_set_time(cmd_type_t'(req_type_i)) && (req_data_i < 16'(MIN_TIME)));
  assign stage_nxt = accept && legal;

`ifdef TRAFFIC_CMD_OFF_BYPASS_EN
  assign flush = stage_vld && (stage_entry.cmd_type == TURN_OFF);
`else
  assign flush = 1'b0;
`endif

  // A flushing push must not race an IDLE pop of an entry that is being discarded.
  assign pop  = (state == S_IDLE) && !fifo_empty && !flush;
  assign push = stage_vld && (!fifo_full || pop || flush);

  // Next occupancy, counting the staged request so the FIFO can never overflow.
  always_comb begin
    lvl_nxt = level_o;
    if (flush) begin
      lvl_nxt = LW'(1);
    end else begin
      if (push) lvl_nxt = lvl_nxt + LW'(1);
      if (pop)  lvl_nxt = lvl_nxt - LW'(1);
    end
    occ_nxt   = {1'b0, lvl_nxt} + {{LW{1'b0}}, stage_nxt};
    ready_nxt = (occ_nxt < (LW+1)'(FIFO_DEPTH));
  end

  // Request front end: validate at transfer, stage legal requests, flag rejects.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_vld   <= 1'b0;
      stage_entry <= '0;
      err_o       <= 1'b0;
      req_ready_o <= 1'b1;
    end else begin
      stage_vld   <= stage_nxt;
      err_o       <= accept && !legal;
      req_ready_o <= ready_nxt;
      if (stage_nxt) begin
        stage_entry.cmd_type <= req_type_i;
        stage_entry.data     <= is_set_time(cmd_type_t'(req_type_i)) ? req_data_i : '0;
      end
    end
  end

  traffic_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (stage_entry),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level_o)
  );

  // Issue FSM: pop in IDLE, strobe for one ISSUE cycle, then hold off for CMD_GAP cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      gap_cnt     <= '0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_data_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cmd_type_o  <= head.cmd_type;
            cmd_data_o  <= head.data;
            cmd_valid_o <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cmd_valid_o <= 1'b0;
          if (CMD_GAP > 0) begin
            gap_cnt <= 8'(CMD_GAP - 1);
            state   <= S_GAP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_IDLE;
          else               gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (level_o != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_traffic_cmd_issuer.sv
// tb_traffic_cmd_issuer: directed, table-driven bench for traffic_cmd_issuer
// (FIFO_DEPTH=4, CMD_GAP=2, MIN_TIME=1).
module tb_traffic_cmd_issuer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [2:0]  req_type_i = '0;
  logic [15:0] req_data_i = '0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  cmd_type_o;
  logic [15:0] cmd_data_o;
  logic        cmd_valid_o;
  logic        err_o;
  logic        busy_o;
  logic [2:0]  level_o;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  logic [2:0]  obs_type[$];
  logic [15:0] obs_data[$];
  int unsigned obs_cyc[$];

  typedef struct {
    logic [2:0]  t;
    logic [15:0] d;
    logic        ok;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs[10];

  traffic_cmd_issuer #(
    .FIFO_DEPTH (4),
    .CMD_GAP    (2),
    .MIN_TIME   (1)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_type_i  (req_type_i),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .cmd_type_o  (cmd_type_o),
    .cmd_data_o  (cmd_data_o),
    .cmd_valid_o (cmd_valid_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .level_o     (level_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every issued command with its cycle number.
  always @(negedge clk_i) begin
    if (!rst_i && cmd_valid_o) begin
      obs_type.push_back(cmd_type_o);
      obs_data.push_back(cmd_data_o);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_req(input logic [2:0] t, input logic [15:0] d);
    req_type_i  = t;
    req_data_i  = d;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while ((busy_o || cmd_valid_o) && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk(name, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic clear_obs();
    obs_type.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  initial begin
    logic [2:0]  last_t;
    logic [15:0] last_d;
    logic [2:0]  bp_t[6];
    logic [15:0] bp_d[6];
    bit          saw_full;
    int unsigned idx;
    int unsigned budget;
    logic        rdy;

    vecs[0] = '{t: 3'd0, d: 16'h1234, ok: 1'b1, ed: 16'd0};
    vecs[1] = '{t: 3'd1, d: 16'd5,    ok: 1'b1, ed: 16'd0};
    vecs[2] = '{t: 3'd2, d: 16'd77,   ok: 1'b1, ed: 16'd0};
    vecs[3] = '{t: 3'd3, d: 16'd500,  ok: 1'b1, ed: 16'd500};
    vecs[4] = '{t: 3'd4, d: 16'd1,    ok: 1'b1, ed: 16'd1};
    vecs[5] = '{t: 3'd5, d: 16'd0,    ok: 1'b0, ed: 16'd0};
    vecs[6] = '{t: 3'd7, d: 16'd9,    ok: 1'b0, ed: 16'd0};
    vecs[7] = '{t: 3'd6, d: 16'd100,  ok: 1'b0, ed: 16'd0};
    vecs[8] = '{t: 3'd5, d: 16'hFFFF, ok: 1'b1, ed: 16'hFFFF};
    vecs[9] = '{t: 3'd3, d: 16'd0,    ok: 1'b0, ed: 16'd0};

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'd0, cmd_valid_o}, 0);
    chk("rst_type",  {29'd0, cmd_type_o}, 0);
    chk("rst_data",  {16'd0, cmd_data_o}, 0);
    chk("rst_err",   {31'd0, err_o}, 0);
    chk("rst_busy",  {31'd0, busy_o}, 0);
    chk("rst_level", {29'd0, level_o}, 0);
    chk("rst_ready", {31'd0, req_ready_o}, 1);
    rst_i = 1'b0;
    tick();
    last_t = 3'd0;
    last_d = 16'd0;

    // Single requests: latency, data forcing, validation, output hold.
    for (int i = 0; i < 10; i++) begin
      chk("vec_lvl_pre", {29'd0, level_o}, 0);
      push_req(vecs[i].t, vecs[i].d);
      chk("vec_err",    {31'd0, err_o}, {31'd0, !vecs[i].ok});
      chk("vec_v_k",    {31'd0, cmd_valid_o}, 0);
      tick();
      chk("vec_lvl_k1", {29'd0, level_o}, {31'd0, vecs[i].ok});
      chk("vec_v_k1",   {31'd0, cmd_valid_o}, 0);
      chk("vec_err_k1", {31'd0, err_o}, 0);
      tick();
      chk("vec_v_k2",   {31'd0, cmd_valid_o}, {31'd0, vecs[i].ok});
      if (vecs[i].ok) begin
        last_t = vecs[i].t;
        last_d = vecs[i].ed;
      end
      chk("vec_type",   {29'd0, cmd_type_o}, {29'd0, last_t});
      chk("vec_data",   {16'd0, cmd_data_o}, {16'd0, last_d});
      chk("vec_lvl_k2", {29'd0, level_o}, 0);
      tick();
      chk("vec_v_k3",   {31'd0, cmd_valid_o}, 0);
      wait_idle("vec_idle");
    end

    // Three queued commands: order, data, spacing of CMD_GAP+2 cycles.
    clear_obs();
    push_req(3'd4, 16'd1000);
    push_req(3'd3, 16'd500);
    push_req(3'd2, 16'd9);
    wait_idle("seq3_idle");
    chk("seq3_count", obs_type.size(), 3);
    if (obs_type.size() >= 3) begin
      chk("seq3_t0", {29'd0, obs_type[0]}, 4);
      chk("seq3_d0", {16'd0, obs_data[0]}, 1000);
      chk("seq3_t1", {29'd0, obs_type[1]}, 3);
      chk("seq3_d1", {16'd0, obs_data[1]}, 500);
      chk("seq3_t2", {29'd0, obs_type[2]}, 2);
      chk("seq3_d2", {16'd0, obs_data[2]}, 0);
      chk("seq3_gap1", obs_cyc[1] - obs_cyc[0], 4);
      chk("seq3_gap2", obs_cyc[2] - obs_cyc[1], 4);
    end

    // Backpressure: hold valid across six requests; nothing may be lost.
    bp_t = '{3'd3, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};
    bp_d = '{16'd100, 16'd101, 16'd102, 16'd0, 16'd0, 16'd105};
    clear_obs();
    saw_full = 1'b0;
    idx = 0;
    budget = 0;
    req_type_i  = bp_t[0];
    req_data_i  = (bp_t[0] >= 3'd3) ? bp_d[0] : 16'd77;
    req_valid_i = 1'b1;
    while (idx < 6 && budget < 200) begin
      rdy = req_ready_o;
      tick();
      budget++;
      if (rdy) idx++;
      if (idx < 6) begin
        req_type_i = bp_t[idx];
        req_data_i = (bp_t[idx] >= 3'd3) ? bp_d[idx] : 16'd77;
      end else begin
        req_valid_i = 1'b0;
      end
      if (level_o > 3'd4) chk("bp_overflow", {29'd0, level_o}, 4);
      if (level_o == 3'd4) begin
        saw_full = 1'b1;
        chk("bp_ready_full", {31'd0, req_ready_o}, 0);
      end
    end
    req_valid_i = 1'b0;
    chk("bp_accept_all", idx, 6);
    chk("bp_saw_full", {31'd0, saw_full}, 1);
    wait_idle("bp_idle");
    chk("bp_count", obs_type.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_type.size()) begin
        chk("bp_type", {29'd0, obs_type[i]}, {29'd0, bp_t[i]});
        chk("bp_data", {16'd0, obs_data[i]}, {16'd0, bp_d[i]});
      end
    end

    // Asynchronous reset during ISSUE.
    push_req(3'd0, 16'd0);
    push_req(3'd2, 16'd0);
    push_req(3'd4, 16'd7);
    chk("rstmid_issue", {31'd0, cmd_valid_o}, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rstmid_valid", {31'd0, cmd_valid_o}, 0);
    chk("rstmid_level", {29'd0, level_o}, 0);
    chk("rstmid_busy",  {31'd0, busy_o}, 0);
    chk("rstmid_ready", {31'd0, req_ready_o}, 1);
    tick();
    rst_i = 1'b0;
    clear_obs();
    repeat (12) tick();
    chk("rstmid_no_issue", obs_type.size(), 0);
    chk("rstmid_level2", {29'd0, level_o}, 0);

`ifdef TRAFFIC_CMD_OFF_BYPASS_EN
    // TURN_OFF flushes queued SET_* entries.
    clear_obs();
    push_req(3'd0, 16'd0);
    push_req(3'd3, 16'd11);
    push_req(3'd4, 16'd22);
    push_req(3'd5, 16'd33);
    push_req(3'd1, 16'd0);
    tick();
    chk("byp_level", {29'd0, level_o}, 1);
    wait_idle("byp_idle");
    chk("byp_count", obs_type.size(), 2);
    if (obs_type.size() >= 2) begin
      chk("byp_first", {29'd0, obs_type[0]}, 0);
      chk("byp_off",   {29'd0, obs_type[1]}, 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
